// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: tick divider, majority-vote bit sampler, frame FSM
// and a single-word output buffer with valid/ready handshake and overrun tracking.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | validating start bit (false start returns to IDLE)
// DATA   | sampling data bits, LSB first
// PARITY | sampling and checking the parity bit
// STOP1  | first stop bit; frame completes here unless two stops
// STOP2  | second stop bit; frame completes at its vote
module uart_rx_os #(
  parameter int DIV_W   = 16,
  parameter int OS      = 16,
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DIV_W-1:0]   divisor,
  input  logic [3:0]         length,
  input  logic               parity_en,
  input  logic               parity_odd,
  input  logic               stop2,
  input  logic               rx,
  output logic [MAX_LEN-1:0] data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               parity_err,
  output logic               frame_err,
  output logic               break_det,
  output logic               overrun,
  output logic               busy
);

  localparam int CW = $clog2(OS);
  localparam logic [CW-1:0] CNT_V0   = CW'(OS / 2 - 1);
  localparam logic [CW-1:0] CNT_V1   = CW'(OS / 2);
  localparam logic [CW-1:0] CNT_VOTE = CW'(OS / 2 + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OS - 1);
  localparam logic [3:0]    LEN_MAX  = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t state, state_nx;

  logic               rx_meta, rx_sync;
  logic [DIV_W-1:0]   div_cnt, div_m1;
  logic               tick;
  logic [CW-1:0]      samp_cnt;
  logic [3:0]         bit_idx;
  logic               v0, v1, maj;
  logic [3:0]         len_cfg, len_l;
  logic               par_en_l, par_odd_l, stop2_l;
  logic [MAX_LEN-1:0] data_sr, bit_mask;
  logic               par_bit, pe_acc, fe_acc, brk_acc;
  logic               at_vote, at_end, last_bit, done, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // divisor 0 behaves as 1, so the terminal count is 0 in both cases
  assign div_m1 = (divisor == '0) ? '0 : divisor - DIV_W'(1);
  assign tick   = en && (div_cnt == div_m1);

  always_ff @(posedge clk) begin
    if (rst || !en)  div_cnt <= '0;
    else if (tick)   div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  always_comb begin
    len_cfg = length;
    if (length < 4'd5)         len_cfg = 4'd5;
    else if (length > LEN_MAX) len_cfg = LEN_MAX;
  end

  assign maj      = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
  assign at_vote  = (samp_cnt == CNT_VOTE);
  assign at_end   = (samp_cnt == CNT_END);
  assign last_bit = (bit_idx == len_l - 4'd1);
  assign bit_mask = {{(MAX_LEN-1){1'b0}}, 1'b1} << bit_idx;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    if (!en) begin
      state_nx = S_IDLE;
    end else if (tick) begin
      case (state)
        S_IDLE:   if (!rx_sync) state_nx = S_START;
        S_START: begin
          if (at_vote && maj) state_nx = S_IDLE;
          else if (at_end)    state_nx = S_DATA;
        end
        S_DATA:   if (at_end && last_bit) state_nx = par_en_l ? S_PARITY : S_STOP1;
        S_PARITY: if (at_end) state_nx = S_STOP1;
        S_STOP1: begin
          if (at_vote && !stop2_l) begin
            state_nx = S_IDLE;
            done     = 1'b1;
          end else if (at_end) begin
            state_nx = S_STOP2;
          end
        end
        S_STOP2: begin
          if (at_vote) begin
            state_nx = S_IDLE;
            done     = 1'b1;
          end
        end
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt  <= '0;
      bit_idx   <= '0;
      v0        <= 1'b1;
      v1        <= 1'b1;
      len_l     <= 4'd5;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
      data_sr   <= '0;
      par_bit   <= 1'b0;
      pe_acc    <= 1'b0;
      fe_acc    <= 1'b0;
      brk_acc   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done;
      if (tick) begin
        if (state == S_IDLE) begin
          // the detecting tick is sample 0 of the start bit
          samp_cnt <= CW'(1);
          if (state_nx == S_START) begin
            bit_idx   <= '0;
            len_l     <= len_cfg;
            par_en_l  <= parity_en;
            par_odd_l <= parity_odd;
            stop2_l   <= stop2;
            data_sr   <= '0;
            par_bit   <= 1'b0;
            pe_acc    <= 1'b0;
            fe_acc    <= 1'b0;
            brk_acc   <= 1'b0;
          end
        end else begin
          samp_cnt <= samp_cnt + CW'(1);
          if (samp_cnt == CNT_V0) v0 <= rx_sync;
          if (samp_cnt == CNT_V1) v1 <= rx_sync;
          if (at_vote) begin
            case (state)
              S_DATA:   if (maj) data_sr <= data_sr | bit_mask;
              S_PARITY: begin
                par_bit <= maj;
                pe_acc  <= maj != ((^data_sr) ^ par_odd_l);
              end
              S_STOP1: begin
                fe_acc  <= !maj;
                brk_acc <= (data_sr == '0) && !par_bit && !maj;
              end
              S_STOP2:  fe_acc <= fe_acc | !maj;
              default:  ;
            endcase
          end
          if (at_end && state == S_DATA) bit_idx <= bit_idx + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_q) begin
      if (data_valid && !data_ready) begin
        overrun <= 1'b1;
      end else begin
        data_out   <= data_sr;
        parity_err <= pe_acc;
        frame_err  <= fe_acc;
        break_det  <= brk_acc;
        overrun    <= 1'b0;
        data_valid <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: divisor 2, OS 16, so one bit is 32 clk.
module tb_uart_rx_os;

  localparam int BIT = 32;

  logic        clk = 1'b0;
  logic        rst, en, parity_en, parity_odd, stop2, rx, data_ready;
  logic [15:0] divisor;
  logic [3:0]  length;
  logic [7:0]  data_out;
  logic        data_valid, parity_err, frame_err, break_det, overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int vcyc     = 0;
  logic [7:0] last_data  = '0;
  logic [3:0] last_flags = '0;

  uart_rx_os #(.DIV_W(16), .OS(16), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst), .en(en), .divisor(divisor), .length(length),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // record every accepted word, sampled between active edges
  always @(negedge clk) begin
    if (data_valid) vcyc++;
    if (data_valid && data_ready) begin
      hs_cnt++;
      last_data  = data_out;
      last_flags = {parity_err, frame_err, break_det, overrun};
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int len, input bit has_par,
                            input bit pbit, input bit s1, input bit has_s2, input bit s2);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < len; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (has_par) begin bits[n] = pbit; n++; end
    bits[n] = s1; n++;
    if (has_s2) begin bits[n] = s2; n++; end
    send_bits(bits, n);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({data_out, data_valid, parity_err, frame_err, break_det, overrun, busy} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {data_out, data_valid, parity_err, frame_err, break_det, overrun, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_8n1;
    int hs0, vc0;
    hs0 = hs_cnt; vc0 = vcyc;
    send_frame(8'hA5, 8, 0, 0, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy: got %b required 0", busy); end
    n_checks++;
    if (hs_cnt - hs0 !== 1) begin n_fail++; $display("FAIL 8n1_words: got %0d required 1", hs_cnt - hs0); end
    n_checks++;
    if (vcyc - vc0 !== 1) begin n_fail++; $display("FAIL 8n1_valid_cycles: got %0d required 1", vcyc - vc0); end
    n_checks++;
    if (last_data !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h required a5", last_data); end
    n_checks++;
    if (last_flags !== 4'b0000) begin n_fail++; $display("FAIL 8n1_flags: got %b required 0000", last_flags); end
    idle(64);
  endtask

  task automatic test_parity;
    length = 4'd7; parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h35, 7, 1, 0, 1, 0, 0);
    idle(64);
    n_checks++;
    if ({last_data, last_flags} !== {8'h35, 4'b0000}) begin
      n_fail++; $display("FAIL parity_good: got %h/%b required 35/0000", last_data, last_flags);
    end
    send_frame(8'h35, 7, 1, 1, 1, 0, 0);
    idle(64);
    n_checks++;
    if ({last_data, last_flags} !== {8'h35, 4'b1000}) begin
      n_fail++; $display("FAIL parity_bad: got %h/%b required 35/1000", last_data, last_flags);
    end
    length = 4'd8; parity_en = 1'b0;
  endtask

  task automatic test_glitch;
    int hs0, bc;
    hs0 = hs_cnt; bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (busy) bc++; end
    rx = 1'b1;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (busy) bc++; end
    n_checks++;
    if (hs_cnt !== hs0 || data_valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_word: got words %0d valid %b required 0 0", hs_cnt - hs0, data_valid);
    end
    n_checks++;
    if (bc == 0 || bc >= 20) begin n_fail++; $display("FAIL glitch_busy: got %0d clk required 1..19", bc); end
    @(posedge clk); #1;
    idle(32);
  endtask

  task automatic test_framing;
    send_frame(8'h3C, 8, 0, 0, 0, 0, 0);
    idle(96);
    n_checks++;
    if ({last_data, last_flags} !== {8'h3C, 4'b0100}) begin
      n_fail++; $display("FAIL frame_err: got %h/%b required 3c/0100", last_data, last_flags);
    end
    send_bits(16'h0000, 10);
    idle(96);
    n_checks++;
    if ({last_data, last_flags} !== {8'h00, 4'b0110}) begin
      n_fail++; $display("FAIL break: got %h/%b required 00/0110", last_data, last_flags);
    end
  endtask

  task automatic test_backpressure;
    int hs0;
    data_ready = 1'b0;
    send_frame(8'h11, 8, 0, 0, 1, 0, 0);
    idle(32);
    send_frame(8'h22, 8, 0, 0, 1, 0, 0);
    idle(32);
    @(negedge clk);
    n_checks++;
    if ({data_valid, data_out, overrun} !== {1'b1, 8'h11, 1'b1}) begin
      n_fail++; $display("FAIL overrun_hold: got v=%b d=%h o=%b required v=1 d=11 o=1",
                         data_valid, data_out, overrun);
    end
    @(posedge clk); #1;
    data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({data_valid, overrun, frame_err, parity_err, break_det} !== 5'b0) begin
      n_fail++; $display("FAIL overrun_clear: got v=%b o=%b required 0 0", data_valid, overrun);
    end
    @(posedge clk); #1;
    hs0 = hs_cnt;
    send_frame(8'h33, 8, 0, 0, 1, 0, 0);
    idle(32);
    n_checks++;
    if (hs_cnt - hs0 !== 1 || {last_data, last_flags} !== {8'h33, 4'b0000}) begin
      n_fail++; $display("FAIL after_overrun: got %0d words %h/%b required 1 33/0000",
                         hs_cnt - hs0, last_data, last_flags);
    end
  endtask

  task automatic test_len_stop2;
    length = 4'd5; stop2 = 1'b1; parity_odd = 1'b1; parity_en = 1'b1;
    send_frame(8'h1B, 5, 1, 1, 1, 1, 1);
    idle(64);
    n_checks++;
    if ({last_data, last_flags} !== {8'h1B, 4'b0000}) begin
      n_fail++; $display("FAIL len5_stop2: got %h/%b required 1b/0000", last_data, last_flags);
    end
    send_frame(8'h1B, 5, 1, 1, 1, 1, 0);
    idle(96);
    n_checks++;
    if ({last_data, last_flags} !== {8'h1B, 4'b0100}) begin
      n_fail++; $display("FAIL stop2_zero: got %h/%b required 1b/0100", last_data, last_flags);
    end
    length = 4'd8; stop2 = 1'b0; parity_odd = 1'b0; parity_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    int hs0;
    data_ready = 1'b0;
    send_frame(8'h77, 8, 0, 0, 1, 0, 0);
    idle(32);
    send_bits(16'b0100, 4);
    rst = 1'b1; rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_out, data_valid, parity_err, frame_err, break_det, overrun, busy} !== 14'h0) begin
      n_fail++; $display("FAIL reset_mid_frame: got %h required 0",
                         {data_out, data_valid, parity_err, frame_err, break_det, overrun, busy});
    end
    @(posedge clk); #1;
    data_ready = 1'b1;
    idle(64);
    hs0 = hs_cnt;
    send_frame(8'h5A, 8, 0, 0, 1, 0, 0);
    idle(32);
    n_checks++;
    if (hs_cnt - hs0 !== 1 || {last_data, last_flags} !== {8'h5A, 4'b0000}) begin
      n_fail++; $display("FAIL after_reset: got %0d words %h/%b required 1 5a/0000",
                         hs_cnt - hs0, last_data, last_flags);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; divisor = 16'd2; length = 4'd8;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; rx = 1'b1; data_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    idle(16);
    test_8n1;
    test_parity;
    test_glitch;
    test_framing;
    test_backpressure;
    test_len_stop2;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised oversampling UART receiver for the UART subsystem.
- Runs on the single system clock and uses an internal sample-tick enable, not derived clocks.
- Supports runtime-selectable length, parity and stop bits, with majority-vote sampling.
- Reports framing, parity, break and overrun status, and delivers each word over a valid/ready handshake to the host-side FIFO or register block.

Parameters:
- DIV_W, 16: width of the sample-rate divisor.
- OS, 16: oversampling factor (ticks per bit); power of two, at least 8.
- MAX_LEN, 8: maximum data bits per frame; width of data_out.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- en  in  1  receiver enable
- divisor  in  DIV_W  clk cycles per sample tick; 0 is treated as 1
- length  in  4  data bits per frame, 5..MAX_LEN
- parity_en  in  1  parity bit present
- parity_odd  in  1  1 = odd parity, 0 = even parity
- stop2  in  1  two stop bits
- rx  in  1  serial input, asynchronous
- data_out  out  MAX_LEN  received word, right-justified, upper bits zero
- data_valid  out  1  word available
- data_ready  in  1  consumer accepts word
- parity_err  out  1  parity mismatch for the held word
- frame_err  out  1  a stop bit sampled 0 for the held word
- break_det  out  1  break condition for the held word
- overrun  out  1  a frame was lost while the word was held
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - All outputs reset to 0.
  - 2-flop rx synchroniser resets to 1.
  - Tick counter resets to 0; FSM resets to IDLE.
- Tick generation:
  - Counter runs 0..divisor-1 and asserts tick for one clk when it equals divisor-1, then wraps.
  - divisor 0 is treated as 1, giving a tick every clk.
- en=0:
  - FSM is forced to IDLE and the tick counter cleared.
  - Output register and flags are retained; the handshake still works.
- Config latch: length, parity_en, parity_odd and stop2 are latched when start is detected; mid-frame changes are ignored.
  - length < 5 is treated as 5.
  - length > MAX_LEN is treated as MAX_LEN.
- Sampling:
  - Per-bit sample counter runs 0..OS-1.
  - The bit value is the majority of synced rx at counts OS/2-1, OS/2 and OS/2+1.
  - The decision is made at count OS/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on a tick with synced rx = 0, go to START with sample count 0.
  - START: at the vote, a result of 1 is a false start -> IDLE with no output; otherwise continue. After OS ticks, go to DATA.
  - DATA: sample length bits LSB first, one per OS ticks. Then go to PARITY if parity_en, else STOP1.
  - PARITY: expected bit = XOR(data) XOR parity_odd; a mismatch sets the parity flag.
  - STOP1: a vote of 0 sets the frame flag. Go to STOP2 if stop2; otherwise the frame completes.
  - STOP2: same check as STOP1; the frame completes.
  - Completion is at the final stop vote. FSM returns to IDLE immediately, so it can resync on the next falling edge within the remaining half bit.
- Break: data all 0, parity bit 0 if enabled, and STOP1 vote 0 -> break_det=1 and frame_err=1.
- Output register:
  - On completion, data_out and the flags load 1 clk after the completing tick; data_valid rises on that same edge.
  - data_valid holds until data_valid && data_ready.
  - Handshake with no new completion: data_valid, parity_err, frame_err, break_det and overrun clear next clk.
  - Completion while data_valid=1 and data_ready=0: the new frame is discarded, the held word is kept unchanged, and overrun is set sticky.
  - Completion in the same clk as a handshake: the new word loads, overrun=0, data_valid stays 1.
- Flags are meaningful only while data_valid=1.
- Reset mid-frame aborts the frame with no output, and clears the buffer and all flags.

Test Plan:
- 8N1, divisor=2, OS=16 (32 clk/bit), send 0xA5, data_ready=1 -> data_out=0xA5, data_valid for 1 clk, all flags 0, busy low after STOP1 mid-bit.
- 7E1 (length=7, parity_en=1, parity_odd=0):
  - Send 0x35 with parity bit 0 -> data_out=0x35, parity_err=0.
  - Repeat with parity bit 1 -> data_out=0x35, parity_err=1.
- Glitch: rx low for 4 sample ticks in IDLE -> START vote 1, return to IDLE, data_valid never asserts, busy high for under OS/2+2 ticks.
- Framing and break:
  - 8N1, send 0x3C with stop bit 0 -> frame_err=1, break_det=0.
  - Hold rx=0 for 10 bit times -> data_out=0x00, frame_err=1, break_det=1.
- Backpressure:
  - data_ready=0; send 0x11 then 0x22 -> data_out=0x11, overrun=1.
  - Raise data_ready -> flags clear next clk.
  - Send 0x33 -> data_out=0x33, overrun=0.
- Length/stop2/reset:
  - length=5, stop2=1, parity_odd=1, parity_en=1, send 0x1B -> data_out=0x1B, parity_err=0.
  - Second STOP bit 0 -> frame_err=1.
  - Pulse rst during DATA -> all outputs 0, next 0x5A frame received correctly.
